// File: rtl/regfile_dump_seq.sv
// Read-port sequencer: sweeps a wrapping range of register-file lines and streams them out on valid/ready.
// Optional DUMP_CHECKSUM_EN adds a running XOR of accepted words on port csum.
module regfile_dump_seq #(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned DATA_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_line,
    input  logic [ADDR_W:0]   num_lines,
    output logic              read_en,
    output logic [ADDR_W-1:0] read_line,
    input  logic [DATA_W-1:0] rf_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_line,
    output logic              out_last,
    output logic              busy,
    output logic              done
`ifdef DUMP_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] csum
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] REM_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] REM_FULL = (ADDR_W+1)'(NUM_REGS);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W:0]     rem_q, rem_d;
    logic                valid_q, valid_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [ADDR_W-1:0]   line_q, line_d;
    logic                last_q, last_d;
    logic                accept;
    logic                load;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            line_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            line_q  <= line_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        valid_d = valid_q;
        data_d  = data_q;
        line_d  = line_q;
        last_d  = last_q;
        read_en = 1'b0;
        accept  = valid_q && out_ready;
        // The output register may reload whenever it is empty or being drained this cycle.
        load    = (state_q == S_READ) && (!valid_q || out_ready);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ptr_d   = base_line;
                    rem_d   = (num_lines == '0) ? REM_FULL : num_lines;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                read_en = load;
                if (load) begin
                    data_d  = rf_data;
                    line_d  = ptr_q;
                    valid_d = 1'b1;
                    last_d  = (rem_q == REM_ONE);
                    ptr_d   = ptr_q + 1'b1;
                    rem_d   = rem_q - 1'b1;
                    if (rem_q == REM_ONE) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (accept) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign read_line = ptr_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_line  = line_q;
    assign out_last  = last_q;
    assign busy      = (state_q == S_READ) || (state_q == S_DRAIN);
    assign done      = (state_q == S_DONE);

`ifdef DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    always_comb begin
        csum_d = csum_q;
        if ((state_q == S_IDLE) && start) begin
            csum_d = '0;
        end else if (accept) begin
            csum_d = csum_q ^ data_q;
        end
    end

    assign csum = csum_q;
`endif

endmodule

// File: tb/tb_regfile_dump_seq.sv
// Randomized self-checking bench for regfile_dump_seq against a queue-based model of the expected dump.
module tb_regfile_dump_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  base_line;
    logic [4:0]  num_lines;
    logic        read_en;
    logic [3:0]  read_line;
    logic [31:0] rf_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_line;
    logic        out_last;
    logic        busy;
    logic        done;
`ifdef DUMP_CHECKSUM_EN
    logic [31:0] csum;
`endif

    logic [31:0] regs [16];
    int unsigned total;
    int unsigned bad;

    logic [3:0]  line_q [$];
    logic [31:0] data_q [$];
    logic [3:0]  rd_q   [$];

    logic        prev_stall;
    logic [31:0] prev_data;
    logic [3:0]  prev_line;
    logic        prev_last;

    regfile_dump_seq #(.NUM_REGS(16), .ADDR_W(4), .DATA_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_line (base_line),
        .num_lines (num_lines),
        .read_en   (read_en),
        .read_line (read_line),
        .rf_data   (rf_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_line  (out_line),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
`ifdef DUMP_CHECKSUM_EN
        ,
        .csum      (csum)
`endif
    );

    // Register file behaviour: combinational read, zero when not enabled.
    assign rf_data = read_en ? regs[read_line] : 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Protocol and data monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_val("stall_valid", out_valid, 1);
                check_val("stall_data", out_data, prev_data);
                check_val("stall_line", out_line, prev_line);
                check_val("stall_last", out_last, prev_last);
            end
            if (out_valid && !out_ready) begin
                check_val("stall_rden", read_en, 0);
            end
            if (read_en) begin
                if (rd_q.size() == 0) check_val("extra_read", 1, 0);
                else check_val("read_line", read_line, rd_q.pop_front());
            end
            if (out_valid && out_ready) begin
                if (line_q.size() == 0) begin
                    check_val("extra_beat", 1, 0);
                end else begin
                    check_val("beat_line", out_line, line_q[0]);
                    check_val("beat_data", out_data, data_q[0]);
                    check_val("beat_last", out_last, (line_q.size() == 1));
                    void'(line_q.pop_front());
                    void'(data_q.pop_front());
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_line  = out_line;
            prev_last  = out_last;
        end
    end

    // mode: 0 ready always high, 1 fixed pattern 1,0,0,1,0,1 from cycle 2, 2 random ready.
    // stray_at: cycle to pulse an extra start (0 = none); rst_at: cycle to assert reset (0 = none).
    task automatic run_dump(input int unsigned b, input int unsigned n, input int unsigned mode,
                            input int unsigned stray_at, input int unsigned rst_at);
        int unsigned cnt;
        int unsigned cyc;
        logic [31:0] x;
        logic        seen;
        logic        pat [6];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        cnt = (n == 0) ? 16 : n;
        x = 32'h0;
        for (int unsigned i = 0; i < cnt; i++) begin
            line_q.push_back(4'((b + i) % 16));
            rd_q.push_back(4'((b + i) % 16));
            data_q.push_back(regs[(b + i) % 16]);
            x = x ^ regs[(b + i) % 16];
        end
        @(posedge clk); #1;
        start = 1'b1;
        base_line = 4'(b);
        num_lines = 5'(n);
        out_ready = 1'b1;
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
            start = (cyc == stray_at);
            if (start) begin
                base_line = 4'd9;
                num_lines = 5'd1;
            end
            case (mode)
                1: out_ready = (cyc >= 2 && cyc < 8) ? pat[cyc-2] : 1'b1;
                2: out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b1;
            endcase
            if (cyc == rst_at) begin
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                start = 1'b0;
                line_q.delete();
                data_q.delete();
                rd_q.delete();
                check_val("rst_valid", out_valid, 0);
                check_val("rst_busy", busy, 0);
                check_val("rst_rden", read_en, 0);
                return;
            end
            if (cyc == 1) check_val("c1_valid", out_valid, 0);
            if (done) begin
                seen = 1'b1;
                if (mode == 0) check_val("done_cyc", cyc, cnt + 2);
                check_val("done_busy", busy, 0);
                check_val("done_qempty", line_q.size(), 0);
`ifdef DUMP_CHECKSUM_EN
                check_val("csum", csum, x);
`endif
            end else begin
                check_val("busy", busy, 1);
            end
        end
        if (!seen) check_val("done_timeout", 0, 1);
        @(posedge clk); #1;
        start = 1'b0;
        check_val("done_pulse", done, 0);
        check_val("idle_busy", busy, 0);
    endtask

    initial begin
        total = 0;
        bad = 0;
        prev_stall = 1'b0;
        reset = 1'b1;
        start = 1'b0;
        base_line = '0;
        num_lines = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) regs[i] = 32'hA000_0000 + 32'(i);
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_valid", out_valid, 0);
        check_val("reset_busy", busy, 0);
        check_val("reset_done", done, 0);
        check_val("reset_rden", read_en, 0);
        check_val("reset_last", out_last, 0);
        check_val("reset_data", out_data, 0);
        check_val("reset_line", out_line, 0);
        reset = 1'b0;

        run_dump(0, 0, 0, 0, 0);   // full sweep
        run_dump(14, 4, 0, 0, 0);  // wrap 14,15,0,1
        run_dump(3, 3, 1, 0, 0);   // backpressure pattern
        run_dump(0, 4, 0, 3, 0);   // start while busy
        run_dump(5, 2, 0, 4, 0);   // start during the done cycle
        repeat (3) begin
            @(posedge clk); #1;
            check_val("post_stray_busy", busy, 0);
        end
        run_dump(0, 0, 0, 0, 4);   // reset after beat 2
        run_dump(6, 5, 0, 0, 0);

        regs[0] = 32'h1;
        regs[1] = 32'h2;
        regs[2] = 32'h4;
        regs[3] = 32'h8;
        run_dump(0, 4, 0, 0, 0);
`ifdef DUMP_CHECKSUM_EN
        check_val("csum_0f", csum, 32'h0000_000F);
`endif

        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 16; i++) regs[i] = $urandom;
            run_dump($urandom_range(0, 15), $urandom_range(0, 16),
                     ($urandom_range(0, 1) == 0) ? 0 : 2, 0, 0);
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_dump_seq.md
Name: regfile_dump_seq

Overview:
- Downstream read-port sequencer for the 16 x 32-bit register file.
- On a start pulse, sweeps a contiguous, wrapping range of register lines through the file's read port (read_en/read_line → data_out).
- Streams each word out on a valid/ready interface tagged with its line number.
- Used for debug dump, context save and register scrub.

Parameters:
- NUM_REGS, 16, number of register-file lines (power of two).
- ADDR_W, 4, line index width (log2 NUM_REGS).
- DATA_W, 32, register word width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  single-cycle request; sampled only in IDLE
- base_line  in  ADDR_W  first line to dump; sampled with start
- num_lines  in  ADDR_W+1  lines to dump, 1..NUM_REGS; 0 treated as NUM_REGS; sampled with start
- read_en  out  1  to register file read_en
- read_line  out  ADDR_W  to register file read_line
- rf_data  in  DATA_W  from register file data_out (combinational, same cycle)
- out_valid  out  1  stream word valid
- out_ready  in  1  downstream accepts when high with out_valid
- out_data  out  DATA_W  dumped word
- out_line  out  ADDR_W  line index of out_data
- out_last  out  1  marks final word of the dump
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the last word is accepted

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high; reset overrides everything, including mid-dump.
- Reset values: all outputs 0; state IDLE; pointer and remaining count cleared.
- States: IDLE, READ, DRAIN, DONE.
- IDLE:
  - start=1 latches ptr=base_line and remaining=num_lines (0→NUM_REGS).
  - Next cycle enters READ with busy=1.
- READ:
  - read_line=ptr.
  - read_en=1 only when the output register can load, i.e. out_valid=0 or out_ready=1.
  - On load: out_data<=rf_data, out_line<=ptr, out_valid<=1, out_last<=(remaining==1); ptr<=ptr+1 mod NUM_REGS (wraps 15→0); remaining<=remaining-1.
  - After loading the final word (remaining==1), go to DRAIN.
- Stall rule: when out_valid=1 and out_ready=0, read_en=0 and out_data/out_line/out_last hold stable. read_line holds ptr.
- DRAIN: read_en=0. When out_valid & out_ready (the last beat), clear out_valid/out_last and go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- Throughput and latency:
  - One word per cycle with out_ready held high.
  - start in cycle 0 → first out_valid in cycle 2.
  - N words end with the last beat in cycle N+1 (ready always high) and done in cycle N+2.
- When read_en=0, rf_data is ignored (the file returns 0).
- start while busy, or in DONE, is ignored.
- Ready/valid: out_valid never drops without a handshake; out_ready may toggle freely.

Optional Feature:
- Macro DUMP_CHECKSUM_EN.
- When defined:
  - Adds output port csum (DATA_W): running XOR of every word accepted in the current dump.
  - Cleared when start is accepted; final value valid and stable from the done cycle until the next accepted start.
  - Reset value 0.
- When undefined: no csum port and no XOR logic; all other behaviour identical.

Test Plan:
- Full dump, ready always 1: preload reg k = 32'hA000_0000+k, start with base=0, num=0 → 16 beats, out_line 0..15, data A000_0000..A000_000F, out_last on line 15, done in cycle 18.
- Wrap-around: base=14, num=4 → out_line 14,15,0,1 with matching data; out_last on line 1 only.
- Backpressure: base=3, num=3, out_ready pattern 1,0,0,1,0,1 → words 3,4,5 delivered once each, in order; outputs stable during stalls; read_en=0 in every stall cycle.
- Ignored start: pulse start with base=9 mid-dump of base=0, num=4 → only lines 0..3 emitted; no second dump.
- Reset mid-operation: assert reset after beat 2 of a 16-line dump → next cycle out_valid=0, busy=0, read_en=0; fresh start dumps correctly from base.
- DUMP_CHECKSUM_EN: regs 0..3 = 1,2,4,8, base=0, num=4 → csum=32'h0000_000F at done.
